// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle RV32I sequencer driving the ALU datapath
module alu_seq_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             take_jmp,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [2:0]       state_o,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ALU     = 3'd0,
        C_JUMP    = 3'd1,
        C_BRANCH  = 3'd2,
        C_LOAD    = 3'd3,
        C_STORE   = 3'd4,
        C_ILLEGAL = 3'd5
    } iclass_t;

    localparam bit          TMO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(MEM_TIMEOUT - 1) : 32'd0;

    state_t           state;
    iclass_t          iclass;
    iclass_t          dec_class;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] retired_q;
    logic [31:0]      tmo_cnt;
    logic             tmo_hit;

    // Classify the opcode presented during DECODE
    always_comb begin
        dec_class = C_ILLEGAL;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: dec_class = C_ALU;
            7'b1101111, 7'b1100111:                         dec_class = C_JUMP;
            7'b1100011:                                     dec_class = C_BRANCH;
            7'b0000011:                                     dec_class = C_LOAD;
            7'b0100011:                                     dec_class = C_STORE;
            default:                                        dec_class = C_ILLEGAL;
        endcase
    end

    // Last permitted wait cycle of a memory access; a ready in this cycle still wins
    always_comb begin
        tmo_hit = TMO_EN && !mem_ready && (tmo_cnt == TMO_LAST);
    end

    // Datapath enables: Moore on state, with mem_ready qualifying the completing access
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                if (iclass == C_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = take_jmp;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (iclass == C_STORE);
                pc_we    = (iclass == C_STORE) && mem_ready;
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                wb_sel = (iclass == C_LOAD);
                pc_sel = (iclass == C_JUMP);
            end
            default: begin
            end
        endcase
    end

    // Sequencer state, latched class, access timeout, trap cause and retire count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            iclass    <= C_ALU;
            cause_q   <= 2'd0;
            retired_q <= '0;
            tmo_cnt   <= '0;
        end else if (pc_we) begin
            // Commit: run decides whether the next instruction starts
            retired_q <= retired_q + CNT_W'(1);
            state     <= run ? S_FETCH : S_IDLE;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state   <= S_FETCH;
                        tmo_cnt <= '0;
                    end
                end
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        state <= (state == S_FETCH) ? S_DECODE : S_WB;
                    end else if (tmo_hit) begin
                        state   <= S_TRAP;
                        cause_q <= 2'd2;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_DECODE: begin
                    iclass <= dec_class;
                    if (dec_class == C_ILLEGAL) begin
                        state   <= S_TRAP;
                        cause_q <= 2'd1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (iclass == C_LOAD || iclass == C_STORE) begin
                        state   <= S_MEM;
                        tmo_cnt <= '0;
                    end else begin
                        state <= S_WB;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign state_o    = state;
    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - instruction-level model checked against alu_seq_ctrl every cycle
module tb_alu_seq_ctrl;

    localparam int TMO = 4;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

    // Flag vector order: mem_req mem_we addr_sel ir_we reg_we wb_sel pc_we pc_sel trap
    localparam logic [8:0] F_REQ = 9'h100, F_MWE = 9'h080, F_ASEL = 9'h040, F_IRWE = 9'h020,
                           F_REGWE = 9'h010, F_WBSEL = 9'h008, F_PCWE = 9'h004,
                           F_PCSEL = 9'h002, F_TRAP = 9'h001;

    localparam logic [6:0] OP_ADD = 7'b0110011, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_BEQ = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n, run, take_jmp, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_we, addr_sel, ir_we, reg_we, wb_sel, pc_we, pc_sel, trap;
    logic [2:0] state_o;
    logic [1:0] trap_cause;
    logic [3:0] retired;
    logic [8:0] dut_fl;

    alu_seq_ctrl #(.CNT_W(4), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .take_jmp(take_jmp),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .state_o(state_o), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    assign dut_fl = {mem_req, mem_we, addr_sel, ir_we, reg_we, wb_sel, pc_we, pc_sel, trap};

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, chk, run, tj, rdy;
        logic [6:0] op;
        logic [2:0] st;
        logic [8:0] fl;
        logic [1:0] cause;
        logic [3:0] ret;
        int         lit_ret, lit_cause;
    } cyc_t;

    cyc_t plan[$];
    cyc_t cur;
    int   cur_idx = -1;
    bit   checking = 0;
    int   n_cmp = 0, n_bad = 0;

    // Instruction-level model state
    int         m_retired = 0, m_cause = 0, m_trap_idx = 0;
    bit         m_idle = 1;
    logic       cur_run = 1'b0, cur_tj = 1'b0;
    logic [6:0] cur_op = 7'h0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at step %0d: got %0h, wanted %0h", name, cur_idx, act, exp);
        end
    endtask

    // 0 alu, 1 jump, 2 branch, 3 load, 4 store, 5 illegal
    function automatic int cls_of(input logic [6:0] op);
        case (op)
            OP_ADD, OP_IMM, OP_LUI, OP_AUIPC: return 0;
            OP_JAL, OP_JALR:                  return 1;
            OP_BEQ:                           return 2;
            OP_LOAD:                          return 3;
            OP_STORE:                         return 4;
            default:                          return 5;
        endcase
    endfunction

    task automatic push(input logic [2:0] st, input logic rdy, input logic [8:0] fl);
        cyc_t c;
        c.rst_n = 1'b1; c.chk = 1'b1; c.run = cur_run; c.tj = cur_tj; c.rdy = rdy;
        c.op = cur_op; c.st = st; c.fl = fl; c.cause = 2'(m_cause); c.ret = 4'(m_retired);
        c.lit_ret = -1; c.lit_cause = -1;
        plan.push_back(c);
    endtask

    task automatic idle_cycles(input int n);
        cur_run = 1'b0;
        for (int k = 0; k < n; k++) push(ST_IDLE, 1'b1, 9'h000);
        m_idle = 1;
    endtask

    task automatic do_reset();
        push(ST_TRAP, 1'b1, F_TRAP);
        plan[plan.size()-1].rst_n = 1'b0;
        plan[plan.size()-1].chk   = 1'b0;
        m_cause = 0;
        m_retired = 0;
        idle_cycles(2);
    endtask

    task automatic trap_fill(input int cause);
        m_cause = cause;
        m_trap_idx = plan.size();
        cur_run = 1'b1;
        for (int k = 0; k < 3; k++) push(ST_TRAP, 1'b1, F_TRAP);
        do_reset();
    endtask

    // A memory access held not-ready for 'waits' cycles; reports a timeout trap
    task automatic wait_phase(input logic [2:0] st, input int waits, input logic [8:0] base,
                              input logic [8:0] on_ready, output bit trapped);
        trapped = 0;
        for (int k = 0; k <= waits; k++) begin
            if (k == waits) begin
                push(st, 1'b1, base | on_ready);
            end else begin
                push(st, 1'b0, base);
                if (k == TMO - 1) begin
                    trapped = 1;
                    return;
                end
            end
        end
    endtask

    task automatic commit(input logic run_end);
        m_retired = (m_retired + 1) % 16;
        if (!run_end) m_idle = 1;
    endtask

    task automatic instr(input logic [6:0] op, input logic tj, input int fw, input int mw,
                         input logic run_end);
        int c;
        bit tr;
        c = cls_of(op);
        cur_op = op; cur_tj = tj; cur_run = 1'b1;
        if (m_idle) begin
            push(ST_IDLE, 1'b1, 9'h000);
            m_idle = 0;
        end
        wait_phase(ST_FETCH, fw, F_REQ, F_IRWE, tr);
        if (tr) begin trap_fill(2); return; end
        push(ST_DECODE, 1'b1, 9'h000);
        if (c == 5) begin trap_fill(1); return; end
        cur_op = ~op;
        cur_run = run_end;
        if (c == 2) begin
            push(ST_EXEC, 1'b1, F_PCWE | (tj ? F_PCSEL : 9'h000));
            commit(run_end);
            return;
        end
        push(ST_EXEC, 1'b1, 9'h000);
        if (c == 3 || c == 4) begin
            wait_phase(ST_MEM, mw, F_REQ | F_ASEL | ((c == 4) ? F_MWE : 9'h000),
                       (c == 4) ? F_PCWE : 9'h000, tr);
            if (tr) begin trap_fill(2); return; end
            if (c == 4) begin commit(run_end); return; end
            push(ST_WB, 1'b1, F_REGWE | F_PCWE | F_WBSEL);
        end else begin
            push(ST_WB, 1'b1, F_REGWE | F_PCWE | ((c == 1) ? F_PCSEL : 9'h000));
        end
        commit(run_end);
    endtask

    task automatic build();
        int n0, n_add, n16;
        n0 = plan.size(); instr(OP_ADD, 1'b1, 0, 0, 1'b1);
        chk("cost_add_from_idle", plan.size() - n0, 5);
        n_add = plan.size();
        n0 = plan.size(); instr(OP_BEQ, 1'b1, 0, 0, 1'b1);
        chk("cost_beq_taken", plan.size() - n0, 3);
        n0 = plan.size(); instr(OP_BEQ, 1'b0, 0, 0, 1'b1);
        chk("cost_beq_not_taken", plan.size() - n0, 3);
        n0 = plan.size(); instr(OP_JAL, 1'b0, 0, 0, 1'b1);
        chk("cost_jal", plan.size() - n0, 4);
        instr(OP_IMM, 1'b1, 0, 0, 1'b1);
        instr(OP_LUI, 1'b0, 0, 0, 1'b1);
        instr(OP_AUIPC, 1'b0, 0, 0, 1'b1);
        instr(OP_JALR, 1'b0, 0, 0, 1'b1);
        n0 = plan.size(); instr(OP_STORE, 1'b0, 0, 0, 1'b1);
        chk("cost_store", plan.size() - n0, 4);
        n0 = plan.size(); instr(OP_LOAD, 1'b0, 0, 0, 1'b1);
        chk("cost_load", plan.size() - n0, 5);
        plan[n_add].lit_ret = 1;
        instr(OP_LOAD, 1'b0, 1, 3, 1'b1);
        instr(OP_STORE, 1'b0, 2, 2, 1'b1);
        instr(OP_ADD, 1'b0, 0, 0, 1'b0);
        idle_cycles(2);
        instr(OP_BAD, 1'b0, 0, 0, 1'b1);
        plan[m_trap_idx].lit_cause = 1;
        instr(OP_ADD, 1'b0, 4, 0, 1'b1);
        plan[m_trap_idx].lit_cause = 2;
        instr(OP_ADD, 1'b0, 3, 0, 1'b1);
        instr(OP_LOAD, 1'b0, 0, 4, 1'b1);
        plan[m_trap_idx].lit_cause = 2;
        for (int k = 0; k < 16; k++) instr(OP_ADD, 1'b0, 0, 0, 1'b1);
        n16 = plan.size();
        instr(OP_ADD, 1'b0, 0, 0, 1'b0);
        plan[n16].lit_ret = 0;
        idle_cycles(2);
        plan[plan.size()-1].lit_ret = 1;
    endtask

    // Compare the DUT against the model's record for the current cycle
    always @(negedge clk) begin
        if (checking && cur.chk) begin
            chk("state_o", int'(state_o), int'(cur.st));
            chk("enables", int'(dut_fl), int'(cur.fl));
            chk("trap_cause", int'(trap_cause), int'(cur.cause));
            chk("retired", int'(retired), int'(cur.ret));
            if (cur.lit_ret >= 0) chk("retired_literal", int'(retired), cur.lit_ret);
            if (cur.lit_cause >= 0) chk("cause_literal", int'(trap_cause), cur.lit_cause);
        end
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = 7'h0; take_jmp = 1'b0; mem_ready = 1'b0;
        build();
        repeat (2) @(posedge clk);
        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            cur = plan[i];
            cur_idx = i;
            rst_n = cur.rst_n;
            run = cur.run;
            opcode = cur.op;
            take_jmp = cur.tj;
            mem_ready = cur.rdy;
            checking = 1;
        end
        @(posedge clk);
        #1;
        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
